// File: rtl/alu_pkg.sv
// Shared ALU writeback definitions: opcode encoding, FSM states, latency width
// and the captured-result record used by alu_writeback.
package alu_pkg;

    localparam int OPC_W  = 5;
    localparam int DEST_W = 4;
    localparam int LAT_W  = 6;

    localparam logic [OPC_W-1:0] ALU_OP_ADD = 5'b10001;
    localparam logic [OPC_W-1:0] ALU_OP_SUB = 5'b10010;
    localparam logic [OPC_W-1:0] ALU_OP_MUL = 5'b10011;
    localparam logic [OPC_W-1:0] ALU_OP_DIV = 5'b10100;
    localparam logic [OPC_W-1:0] ALU_OP_AND = 5'b10101;
    localparam logic [OPC_W-1:0] ALU_OP_OR  = 5'b10110;
    localparam logic [OPC_W-1:0] ALU_OP_XOR = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } wb_state_e;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [31:0]       hi;
        logic [31:0]       lo;
        logic              hi_we;
        logic              zero;
    } wb_data_t;

    // MUL and DIV produce a full 64-bit result and may need extra cycles.
    function automatic logic is_long_op(input logic [OPC_W-1:0] opc);
        return (opc == ALU_OP_MUL) || (opc == ALU_OP_DIV);
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter for multi-cycle ALU ops; tc_o flags the last wait cycle.
module alu_lat_counter
    import alu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - LAT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == LAT_W'(1));

endmodule

// File: rtl/alu_writeback.sv
// Captures the ALU result after the opcode's latency and holds it for the
// register file handshake. Optional abort input under macro ALU_WB_ABORT_EN.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              op_valid,
    output logic              op_ready,
`ifdef ALU_WB_ABORT_EN
    input  logic              abort,
`endif
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DEST_W-1:0] dest,
    input  logic [63:0]       alu_result,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DEST_W-1:0] wb_dest,
    output logic [31:0]       wb_lo,
    output logic [31:0]       wb_hi,
    output logic              hi_we,
    output logic              zero_flag,
    output logic              busy
);

    wb_state_e         state_q;
    logic [OPC_W-1:0]  opc_q;
    logic [DEST_W-1:0] dest_q;
    logic              wb_valid_q;
    wb_data_t          wb_q;
    wb_data_t          cap_d;

    logic              accept;
    logic              start_wait;
    logic              cap_long;
    logic [LAT_W-1:0]  op_lat;
    logic              cnt_tc;
    logic              abort_hit;

`ifdef ALU_WB_ABORT_EN
    assign abort_hit = abort && (state_q != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign op_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign accept     = op_valid && op_ready;
    assign op_lat     = (opcode == ALU_OP_MUL) ? LAT_W'(MUL_LAT) : LAT_W'(DIV_LAT);
    assign start_wait = is_long_op(opcode) && (op_lat != '0);

    // In IDLE the live opcode/dest are captured; from WAIT the latched ones.
    assign cap_long = (state_q == ST_IDLE) ? is_long_op(opcode) : is_long_op(opc_q);

    always_comb begin
        cap_d       = '0;
        cap_d.dest  = (state_q == ST_IDLE) ? dest : dest_q;
        cap_d.hi    = alu_result[63:32];
        cap_d.lo    = alu_result[31:0];
        cap_d.hi_we = cap_long;
        cap_d.zero  = cap_long ? (alu_result == 64'd0) : (alu_result[31:0] == 32'd0);
    end

    alu_lat_counter u_lat_cnt (
        .clk_i      (clk),
        .rst_ni     (clr),
        .clear_i    (abort_hit),
        .load_i     (accept && start_wait),
        .load_val_i (op_lat),
        .dec_i      (state_q == ST_WAIT),
        .tc_o       (cnt_tc)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= ST_IDLE;
            opc_q      <= '0;
            dest_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        opc_q  <= opcode;
                        dest_q <= dest;
                        if (start_wait) begin
                            state_q <= ST_WAIT;
                        end else begin
                            wb_q       <= cap_d;
                            wb_valid_q <= 1'b1;
                            state_q    <= ST_HOLD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (abort_hit) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_tc) begin
                        wb_q       <= cap_d;
                        wb_valid_q <= 1'b1;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Data stays visible after the handshake; only the enables drop.
                    if (abort_hit || wb_ready) begin
                        wb_valid_q <= 1'b0;
                        wb_q.hi_we <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_dest   = wb_q.dest;
    assign wb_lo     = wb_q.lo;
    assign wb_hi     = wb_q.hi;
    assign hi_we     = wb_q.hi_we;
    assign zero_flag = wb_q.zero;

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized self-checking bench for alu_writeback against a latency/capture model.
module tb_alu_writeback;

    localparam int MUL_LAT = 1;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        clr;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  opcode;
    logic [3:0]  dest;
    logic [63:0] alu_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_dest;
    logic [31:0] wb_lo;
    logic [31:0] wb_hi;
    logic        hi_we;
    logic        zero_flag;
    logic        busy;
`ifdef ALU_WB_ABORT_EN
    logic        abort;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_writeback #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk        (clk),
        .clr        (clr),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
`ifdef ALU_WB_ABORT_EN
        .abort      (abort),
`endif
        .opcode     (opcode),
        .dest       (dest),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_dest    (wb_dest),
        .wb_lo      (wb_lo),
        .wb_hi      (wb_hi),
        .hi_we      (hi_we),
        .zero_flag  (zero_flag),
        .busy       (busy)
    );

    // Model: edges after the accept edge at which the result is sampled.
    function automatic int exp_lat(input logic [4:0] opc);
        if (opc == 5'b10011) return MUL_LAT;
        if (opc == 5'b10100) return DIV_LAT;
        return 0;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, follow it through wait/hold/backpressure and check against the model.
    task automatic do_op(input logic [4:0] opc, input logic [3:0] dst, input logic [63:0] v0,
                         input bit fixed, input int stall, input string tag);
        int          lat;
        int          n;
        bit          lng;
        logic [63:0] cap;
        logic [63:0] v;
        logic        exp_z;
        lat = exp_lat(opc);
        lng = (opc == 5'b10011) || (opc == 5'b10100);
        n_chk++;
        if (op_ready !== 1'b1) $display("FAIL %s ready_before_accept got %b want 1", tag, op_ready);
        else n_pass++;
        op_valid = 1'b1; opcode = opc; dest = dst; alu_result = v0; cap = v0;
        tick();
        opcode = 5'($urandom()); dest = 4'($urandom());
        n = 0;
        while (wb_valid !== 1'b1 && n < lat + 4) begin
            n_chk++;
            if (busy !== 1'b1 || op_ready !== 1'b0)
                $display("FAIL %s wait_busy got busy=%b ready=%b want 1/0", tag, busy, op_ready);
            else n_pass++;
            op_valid = 1'($urandom_range(0, 1));
            opcode   = 5'($urandom());
            dest     = 4'($urandom());
            wb_ready = 1'($urandom_range(0, 1));
            v = fixed ? v0 : rnd64();
            alu_result = v;
            n++;
            if (n == lat) cap = v;
            tick();
        end
        n_chk++;
        if (n != lat) $display("FAIL %s latency got %0d want %0d", tag, n, lat);
        else n_pass++;
        exp_z = lng ? (cap == 64'd0) : (cap[31:0] == 32'd0);
        wb_ready = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            n_chk++;
            if ({wb_valid, op_ready, busy, wb_dest, wb_hi, wb_lo, hi_we, zero_flag} !==
                {1'b1, 1'b0, 1'b1, dst, cap[63:32], cap[31:0], lng, exp_z})
                $display("FAIL %s hold[%0d] got v=%b rdy=%b d=%h hi=%h lo=%h we=%b z=%b want d=%h hi=%h lo=%h we=%b z=%b",
                         tag, s, wb_valid, op_ready, wb_dest, wb_hi, wb_lo, hi_we, zero_flag,
                         dst, cap[63:32], cap[31:0], lng, exp_z);
            else n_pass++;
            if (s < stall) begin
                op_valid = 1'b1; opcode = 5'($urandom()); alu_result = rnd64();
                tick();
            end
        end
        op_valid = 1'b0; wb_ready = 1'b1;
        tick();
        // Second edge with wb_ready high in IDLE must change nothing.
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if ({wb_valid, busy, op_ready, hi_we, wb_dest, wb_hi, wb_lo, zero_flag} !==
                {1'b0, 1'b0, 1'b1, 1'b0, dst, cap[63:32], cap[31:0], exp_z})
                $display("FAIL %s release[%0d] got v=%b busy=%b rdy=%b we=%b d=%h lo=%h want 0/0/1/0 d=%h lo=%h",
                         tag, k, wb_valid, busy, op_ready, hi_we, wb_dest, wb_lo, dst, cap[31:0]);
            else n_pass++;
            if (k == 0) tick();
        end
        wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0; op_valid = 1'b0; opcode = '0; dest = '0; alu_result = '0; wb_ready = 1'b0;
`ifdef ALU_WB_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        n_chk++;
        if ({wb_valid, busy, hi_we, zero_flag, wb_lo, wb_hi, wb_dest} !== 71'd0)
            $display("FAIL reset_state got v=%b busy=%b we=%b z=%b lo=%h hi=%h d=%h want all 0",
                     wb_valid, busy, hi_we, zero_flag, wb_lo, wb_hi, wb_dest);
        else n_pass++;
        tick(); tick();
        clr = 1'b1;
        tick();
        n_chk++;
        if (op_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release got rdy=%b busy=%b want 1/0", op_ready, busy);
        else n_pass++;
    endtask

    task automatic test_add();
        do_op(5'b10001, 4'd3, 64'h5, 1'b1, 0, "add");
    endtask

    task automatic test_div();
        do_op(5'b10100, 4'd9, rnd64(), 1'b0, 0, "div");
    endtask

    task automatic test_backpressure();
        do_op(5'b10001, 4'd7, rnd64(), 1'b1, 5, "bp_add");
        do_op(5'b10011, 4'd2, rnd64(), 1'b0, 5, "bp_mul");
    endtask

    task automatic test_zero_flag();
        do_op(5'b10011, 4'd1, 64'h1_0000_0000, 1'b1, 0, "zero_mul");
        do_op(5'b10101, 4'd1, 64'h1_0000_0000, 1'b1, 0, "zero_and");
        do_op(5'b10100, 4'd4, 64'h0, 1'b1, 0, "zero_div");
    endtask

    task automatic test_undefined();
        do_op(5'b00000, 4'd5, 64'hFFFF_FFFF_0000_0000, 1'b1, 1, "undef0");
        do_op(5'b11111, 4'd6, rnd64(), 1'b0, 0, "undef1f");
    endtask

    task automatic test_reset_mid_div();
        int seen;
        op_valid = 1'b1; opcode = 5'b10100; dest = 4'd8; alu_result = rnd64();
        tick();
        op_valid = 1'b0;
        repeat (9) tick();
        #2 clr = 1'b0;
        #1;
        n_chk++;
        if ({wb_valid, busy, hi_we, zero_flag, wb_lo, wb_hi, wb_dest} !== 71'd0)
            $display("FAIL rst_mid_div got v=%b busy=%b want 0/0", wb_valid, busy);
        else n_pass++;
        tick();
        clr = 1'b1;
        seen = 0;
        repeat (40) begin
            alu_result = rnd64();
            tick();
            if (wb_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_chk++;
        if (seen != 0) $display("FAIL rst_discard got %0d active cycles want 0", seen);
        else n_pass++;
        do_op(5'b10001, 4'd3, 64'h5, 1'b1, 0, "add_after_rst");
    endtask

    task automatic test_random();
        logic [4:0] opc;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: opc = 5'b10011;
                1: opc = 5'b10100;
                2: opc = 5'b10001;
                default: opc = 5'($urandom());
            endcase
            do_op(opc, 4'($urandom()), rnd64(), 1'b0, int'($urandom_range(0, 3)), "rand");
        end
    endtask

`ifdef ALU_WB_ABORT_EN
    task automatic test_abort();
        int seen;
        op_valid = 1'b1; opcode = 5'b10001; dest = 4'd2; alu_result = rnd64();
        tick();
        op_valid = 1'b0; abort = 1'b1; wb_ready = 1'b1;
        tick();
        abort = 1'b0; wb_ready = 1'b0;
        n_chk++;
        if (wb_valid !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1)
            $display("FAIL abort_hold got v=%b busy=%b rdy=%b want 0/0/1", wb_valid, busy, op_ready);
        else n_pass++;
        op_valid = 1'b1; opcode = 5'b10100; dest = 4'd4;
        tick();
        op_valid = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        seen = 0;
        repeat (40) begin
            if (wb_valid !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        n_chk++;
        if (seen != 0) $display("FAIL abort_wait got %0d active cycles want 0", seen);
        else n_pass++;
        do_op(5'b10001, 4'd3, 64'h5, 1'b1, 0, "add_after_abort");
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_div();
        test_backpressure();
        test_zero_flag();
        test_undefined();
        test_reset_mid_div();
        test_random();
`ifdef ALU_WB_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
